// File: rtl/graycode_bist.sv
// graycode_bist -- built-in self-test sequencer for the graycode converter.
//
// Drives the converter's binary input through PASSES upward sweeps with
// wrap-around, followed by one downward sweep. On every applied vector it
// checks the round-trip output and the single-bit adjacency of the gray code.
// It reports pass/fail, a saturating error count and the first failing vector.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   start_i           start a run (sampled only while idle)
//   abort_i           stop a run (honoured only while sweeping)
//   a_o               binary stimulus to the converter input
//   b_i               gray output of the converter
//   c_i               binary round-trip output of the converter
//   busy_o            high while vectors are being applied
//   done_o            one-cycle pulse on normal completion
//   pass_o            high after a completed run with zero errors
//   err_cnt_o         saturating count of failing vectors
//   first_err_valid_o a first failing vector has been captured
//   first_err_a_o     stimulus value of the first failing vector
module graycode_bist #(
  parameter int N      = 8,
  parameter int PASSES = 2,
  parameter int ERR_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [N-1:0]     a_o,
  input  logic [N-1:0]     b_i,
  input  logic [N-1:0]     c_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             first_err_valid_o,
  output logic [N-1:0]     first_err_a_o
);

  // The pass counter has to be able to reach PASSES.
  localparam int PW = $clog2(PASSES + 1);

  localparam logic [N-1:0]     A_ONE     = N'(1);
  localparam logic [N-1:0]     A_MAX     = {N{1'b1}};
  localparam logic [PW-1:0]    PCNT_ONE  = PW'(1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [N-1:0]     a_r, a_s;
  logic [N-1:0]     a_prev_r, b_prev_r;
  logic [PW-1:0]    pcnt_r, pcnt_s;
  logic             busy_r, done_r, pass_r;
  logic [ERR_W-1:0] err_r, err_s;
  logic             fv_r;
  logic [N-1:0]     fa_r;

  logic             sweeping_s;
  logic             start_s;
  logic [N-1:0]     dist_s, exp_dist_s;
  logic             vec_fail_s;

  // Number of set bits; an N-bit result always has room for the count N.
  function automatic logic [N-1:0] popcount(input logic [N-1:0] v);
    logic [N-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + N'(v[i]);
    end
    return cnt;
  endfunction

  // Vector check: round trip must match, and the gray code must move by
  // exactly one bit when the stimulus changed and by none when it repeated.
  always_comb begin
    sweeping_s = (state_r == UP) || (state_r == DOWN);
    start_s    = (state_r == IDLE) && start_i;
    dist_s     = popcount(b_i ^ b_prev_r);
    exp_dist_s = (a_r != a_prev_r) ? A_ONE : '0;
    vec_fail_s = sweeping_s && ((c_i != a_r) || (dist_s != exp_dist_s));
    if (vec_fail_s && (err_r != ERR_MAX)) begin
      err_s = err_r + ERR_ONE;
    end else begin
      err_s = err_r;
    end
  end

  // Next-state and next-stimulus logic for the sweep sequencer.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    pcnt_s  = pcnt_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = UP;
          a_s     = '0;
          pcnt_s  = '0;
        end else begin
          state_s = IDLE;
        end
      end
      UP: begin
        if (abort_i) begin
          state_s = IDLE;
        end else if (a_r == A_MAX) begin
          pcnt_s = pcnt_r + PCNT_ONE;
          if (pcnt_r == PASS_LAST) begin
            // Hold the top value so the turn repeats it once.
            state_s = DOWN;
          end else begin
            a_s = '0;
          end
        end else begin
          a_s = a_r + A_ONE;
        end
      end
      DOWN: begin
        if (abort_i) begin
          state_s = IDLE;
        end else if (a_r == '0) begin
          state_s = DONE;
        end else begin
          a_s = a_r - A_ONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, stimulus, history and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= IDLE;
      a_r      <= '0;
      pcnt_r   <= '0;
      a_prev_r <= '0;
      b_prev_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= '0;
      fv_r     <= 1'b0;
      fa_r     <= '0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      pcnt_r  <= pcnt_s;
      busy_r  <= (state_s == UP) || (state_s == DOWN);
      done_r  <= (state_s == DONE);
      if (start_s) begin
        a_prev_r <= '0;
        b_prev_r <= '0;
        pass_r   <= 1'b0;
        err_r    <= '0;
        fv_r     <= 1'b0;
        fa_r     <= '0;
      end else if (sweeping_s) begin
        a_prev_r <= a_r;
        b_prev_r <= b_i;
        err_r    <= err_s;
        if (vec_fail_s && !fv_r) begin
          fv_r <= 1'b1;
          fa_r <= a_r;
        end else begin
          fv_r <= fv_r;
          fa_r <= fa_r;
        end
        // Verdict includes the final vector checked on this same edge.
        if (state_s == DONE) begin
          pass_r <= (err_s == '0);
        end else begin
          pass_r <= pass_r;
        end
      end else begin
        a_prev_r <= a_prev_r;
        b_prev_r <= b_prev_r;
        err_r    <= err_r;
        fv_r     <= fv_r;
        fa_r     <= fa_r;
        pass_r   <= pass_r;
      end
    end
  end

  assign a_o               = a_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign pass_o            = pass_r;
  assign err_cnt_o         = err_r;
  assign first_err_valid_o = fv_r;
  assign first_err_a_o     = fa_r;

endmodule
